// File: rtl/cdt_sample_feeder_pkg.sv
// Shared constants, encodings and helpers for the CDT sampler front end:
// security levels, per-matrix sample counts, beat arithmetic and CDT tables.
package cdt_sample_feeder_pkg;

    localparam int LANE_W = 16;

    typedef enum logic [1:0] {
        SEC_640     = 2'b00,
        SEC_976     = 2'b01,
        SEC_1344    = 2'b10,
        SEC_INVALID = 2'b11
    } sec_lvl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } state_e;

    // n * nbar error samples per matrix for each parameter set
    localparam logic [13:0] SAMPLES_640  = 14'd5120;
    localparam logic [13:0] SAMPLES_976  = 14'd7808;
    localparam logic [13:0] SAMPLES_1344 = 14'd10752;

    // Cumulative distribution thresholds used by the downstream sampler
    localparam int CDT_640_LEN  = 13;
    localparam int CDT_976_LEN  = 11;
    localparam int CDT_1344_LEN = 7;
    localparam logic [15:0] CDT_640 [CDT_640_LEN] = '{
        16'd4643, 16'd13363, 16'd20579, 16'd25843, 16'd29227, 16'd31145, 16'd32103,
        16'd32525, 16'd32689, 16'd32745, 16'd32762, 16'd32766, 16'd32767};
    localparam logic [15:0] CDT_976 [CDT_976_LEN] = '{
        16'd5638, 16'd15915, 16'd23689, 16'd28571, 16'd31116, 16'd32217,
        16'd32613, 16'd32731, 16'd32760, 16'd32766, 16'd32767};
    localparam logic [15:0] CDT_1344 [CDT_1344_LEN] = '{
        16'd9142, 16'd23462, 16'd30338, 16'd32361, 16'd32725, 16'd32765, 16'd32767};

    function automatic logic [13:0] total_samples(input logic [1:0] lvl);
        case (lvl)
            SEC_640:  return SAMPLES_640;
            SEC_976:  return SAMPLES_976;
            SEC_1344: return SAMPLES_1344;
            default:  return 14'd0;
        endcase
    endfunction

    // Input beats needed to cover the given number of 16-bit lanes
    function automatic int ceil_beats(input int lanes, input int in_w);
        return (lanes * LANE_W + in_w - 1) / in_w;
    endfunction

endpackage

// File: rtl/cdt_sample_feeder.sv
// Packs XOF beats into PARALLEL_NUM x 16-bit blocks for the CDT sampler and
// tracks the remaining samples of one error matrix, flagging the final block.
module cdt_sample_feeder
    import cdt_sample_feeder_pkg::*;
#(
    parameter int PARALLEL_NUM = 28,
    parameter int IN_W         = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [1:0]                     sec_lvl,
    input  logic [IN_W-1:0]                in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [LANE_W*PARALLEL_NUM-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [5:0]                     out_lanes,
    output logic                           busy,
    output logic                           done
);

    localparam int BLOCK_W   = LANE_W * PARALLEL_NUM;
    localparam int BEATS_MAX = BLOCK_W / IN_W;
    localparam int BIDX_W    = (BEATS_MAX > 1) ? $clog2(BEATS_MAX + 1) : 1;

    state_e              state_reg, state_next;
    logic [13:0]         remaining_reg, remaining_next;
    logic [BIDX_W-1:0]   beat_idx_reg, beat_idx_next;
    logic                out_valid_reg, out_valid_next;
    logic                out_last_reg, out_last_next;
    logic [5:0]          out_lanes_reg, out_lanes_next;
    logic                done_reg;
    logic                clear_block;
    logic                beat_accept;
    logic [5:0]          lanes_now;
    logic [BIDX_W-1:0]   last_beat;

    assign in_ready    = (state_reg == FILL);
    assign beat_accept = in_ready && in_valid;
    assign busy        = (state_reg == FILL) || (state_reg == HOLD);
    assign done        = done_reg;
    assign out_valid   = out_valid_reg;
    assign out_last    = out_last_reg;
    assign out_lanes   = out_lanes_reg;

    assign lanes_now = (remaining_reg > 14'(PARALLEL_NUM)) ? 6'(PARALLEL_NUM)
                                                           : remaining_reg[5:0];
    assign last_beat = BIDX_W'(ceil_beats(int'(lanes_now), IN_W) - 1);

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        beat_idx_next  = beat_idx_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        out_lanes_next = out_lanes_reg;
        clear_block    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (sec_lvl == SEC_INVALID) begin
                        state_next = FIN;
                    end else begin
                        remaining_next = total_samples(sec_lvl);
                        beat_idx_next  = '0;
                        state_next     = FILL;
                    end
                end
            end
            FILL: begin
                if (beat_accept) begin
                    if (beat_idx_reg == last_beat) begin
                        out_lanes_next = lanes_now;
                        out_last_next  = (remaining_reg <= 14'(PARALLEL_NUM));
                        out_valid_next = 1'b1;
                        state_next     = HOLD;
                    end else begin
                        beat_idx_next = beat_idx_reg + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_valid_reg && out_ready) begin
                    remaining_next = remaining_reg - 14'(out_lanes_reg);
                    beat_idx_next  = '0;
                    clear_block    = 1'b1;
                    out_valid_next = 1'b0;
                    out_last_next  = 1'b0;
                    state_next     = out_last_reg ? FIN : FILL;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            beat_idx_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_lanes_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            beat_idx_reg  <= beat_idx_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            out_lanes_reg <= out_lanes_next;
            done_reg      <= (state_reg == FIN);
        end
    end

    // One register slice per beat position; unwritten slices stay zero
    genvar gi;
    generate
        for (gi = 0; gi < BEATS_MAX; gi++) begin : g_beat
            logic [IN_W-1:0] beat_reg;
            always_ff @(posedge clk) begin
                if (rst || clear_block) begin
                    beat_reg <= '0;
                end else if (beat_accept && (beat_idx_reg == BIDX_W'(gi))) begin
                    beat_reg <= in_data;
                end
            end
            assign out_data[gi*IN_W +: IN_W] = beat_reg;
        end
    endgenerate

endmodule

// File: tb/tb_cdt_sample_feeder.sv
// Scoreboard bench for cdt_sample_feeder: expected blocks are generated from the
// sample-count model at start and compared at each output handshake.
module tb_cdt_sample_feeder;

    localparam int P       = 28;
    localparam int IN_W    = 64;
    localparam int BLOCK_W = 16 * P;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [1:0]         sec_lvl;
    logic [IN_W-1:0]    in_data;
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [5:0]         out_lanes;
    logic               busy;
    logic               done;

    cdt_sample_feeder #(.PARALLEL_NUM(P), .IN_W(IN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sec_lvl   (sec_lvl),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_lanes (out_lanes),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BLOCK_W-1:0] data;
        logic [5:0]         lanes;
        logic               last;
    } blk_t;

    blk_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt;
    int   blk_cnt;

    function automatic int model_total(input int lvl);
        case (lvl)
            0:       return 5120;
            1:       return 7808;
            2:       return 10752;
            default: return 0;
        endcase
    endfunction

    // Expected blocks built from beat k = base + k over accepted beats only
    task automatic push_expected(input int lvl, input logic [63:0] base, output int beats);
        int   rem;
        int   k;
        int   lanes;
        int   nb;
        blk_t b;
        rem = model_total(lvl);
        k   = 0;
        while (rem > 0) begin
            lanes  = (rem > P) ? P : rem;
            nb     = (lanes * 16 + IN_W - 1) / IN_W;
            b.data = '0;
            for (int j = 0; j < nb; j++) begin
                b.data[j*IN_W +: IN_W] = base + 64'(k);
                k++;
            end
            b.lanes = 6'(lanes);
            b.last  = (rem <= P);
            exp_q.push_back(b);
            rem -= lanes;
        end
        beats = k;
    endtask

    task automatic run_matrix(input int lvl, input logic [63:0] base, input int stall,
                              input int gap_pct, input bit midstart, input int stop_beats,
                              input string name);
        int                 exp_beats;
        int                 exp_blocks;
        int                 cyc;
        int                 hold_cnt;
        int                 last_hs_cyc;
        bit                 fin_seen;
        bit                 prev_valid;
        logic [BLOCK_W-1:0] hold_data;
        blk_t               e;
        exp_q.delete();
        push_expected(lvl, base, exp_beats);
        exp_blocks  = exp_q.size();
        acc_cnt     = 0;
        blk_cnt     = 0;
        hold_cnt    = 0;
        prev_valid  = 1'b0;
        last_hs_cyc = -100;
        fin_seen    = 1'b0;
        hold_data   = '0;
        @(negedge clk);
        start     = 1'b1;
        sec_lvl   = 2'(lvl);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cyc       = 0;
        while (!fin_seen && cyc < 30000) begin
            @(negedge clk);
            start   = 1'b0;
            sec_lvl = 2'(lvl);
            if (stop_beats > 0 && acc_cnt == stop_beats) begin
                in_valid = 1'b0;
                exp_q.delete();
                $display("%s: stopped after %0d beats, %0d blocks", name, acc_cnt, blk_cnt);
                return;
            end
            if (done) begin
                fin_seen = 1'b1;
                checks++;
                if (cyc - last_hs_cyc !== 2 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_timing: done %0d cycles after last block (busy=%0b), required 2 (busy=0)",
                             name, cyc - last_hs_cyc, busy);
                end
            end
            if (out_valid) begin
                if (!prev_valid) hold_data = out_data;
                checks++;
                if (out_data !== hold_data || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s hold_stable: in_ready=%0b data=%h, required in_ready=0 data=%h",
                             name, in_ready, out_data, hold_data);
                end
                hold_cnt++;
            end
            prev_valid = out_valid;
            out_ready  = (stall == 0) ? 1'b1 : (out_valid && hold_cnt > stall);
            if (out_valid && out_ready) begin
                blk_cnt++;
                hold_cnt    = 0;
                prev_valid  = 1'b0;
                last_hs_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_block: block %0d produced, required %0d blocks",
                             name, blk_cnt - 1, exp_blocks);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_lanes !== e.lanes || out_last !== e.last) begin
                        errors++;
                        $display("FAIL %s block %0d: lanes=%0d last=%0b data=%h, required lanes=%0d last=%0b data=%h",
                                 name, blk_cnt - 1, out_lanes, out_last, out_data, e.lanes, e.last, e.data);
                    end else begin
                        $display("%s block %0d lanes=%0d last=%0b", name, blk_cnt - 1, out_lanes, out_last);
                    end
                end
            end
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = in_valid ? (base + 64'(acc_cnt)) : {$urandom, $urandom};
            if (in_valid && in_ready) acc_cnt++;
            if (midstart && cyc == 300) begin
                start   = 1'b1;
                sec_lvl = 2'b10;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (!fin_seen) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        end
        checks++;
        if (blk_cnt !== exp_blocks || acc_cnt !== exp_beats || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s totals: blocks=%0d beats=%0d, required blocks=%0d beats=%0d",
                     name, blk_cnt, acc_cnt, exp_blocks, exp_beats);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%0b busy=%0b, required 0 0", name, done, busy);
        end
        $display("%s: %0d blocks, %0d beats, %0d samples", name, blk_cnt, acc_cnt, model_total(lvl));
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            out_last !== 1'b0 || out_lanes !== 6'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL %s: valid=%0b ready=%0b busy=%0b done=%0b last=%0b lanes=%0d data=%h, required all 0",
                     name, out_valid, in_ready, busy, done, out_last, out_lanes, out_data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        sec_lvl = 2'b00;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("start_during_reset");
        $display("test_reset done");
    endtask

    task automatic test_invalid_level();
        @(negedge clk);
        start   = 1'b1;
        sec_lvl = 2'b11;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_cycle1: done=%0b valid=%0b busy=%0b, required 0 0 0", done, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_cycle2: done=%0b valid=%0b busy=%0b, required 1 0 0", done, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL invalid_cycle3: done=%0b valid=%0b busy=%0b, required 0 0 0", done, out_valid, busy);
        end
        $display("test_invalid_level done");
    endtask

    task automatic test_reset_mid_matrix();
        run_matrix(0, 64'hDEAD_0000_0000_0000, 0, 0, 1'b0, 10 * 7 + 3, "reset_mid_pre");
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_mid_idle");
        run_matrix(0, 64'h5A5A_0000_0000_1000, 0, 0, 1'b0, 0, "after_reset_640");
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        sec_lvl   = 2'b00;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        run_matrix(0, 64'h0000_0000_0000_0000, 0, 0, 1'b0, 0, "full_640");
        run_matrix(2, 64'h1111_2222_3333_0000, 0, 0, 1'b0, 0, "full_1344");
        run_matrix(1, 64'h0123_4567_89AB_0000, 5, 0, 1'b0, 0, "stall_976");
        test_invalid_level();
        test_reset_mid_matrix();
        run_matrix(0, 64'hCAFE_F00D_0000_0000, 0, 30, 1'b1, 0, "gaps_midstart_640");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
